// File: rtl/ipv4_checksum_insert.sv
// ipv4_checksum_insert: buffers an IPv4 header byte stream, computes the
// ones-complement header checksum (checksum field summed as zero) and
// replays the header with the checksum field overwritten.
// Optional build macro IPV4_CHECKSUM_IHL_CHECK_EN: drop frames whose IHL
// nibble is below 5 or disagrees with the received length.
module ipv4_checksum_insert #(
  parameter int MAX_HDR_BYTES = 60,
  parameter int CKSUM_OFFSET  = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        cksum_done,
  output logic [15:0] cksum_value,
  output logic        hdr_error
);

  localparam int CW = $clog2(MAX_HDR_BYTES + 1);
  localparam int AW = (MAX_HDR_BYTES > 1) ? $clog2(MAX_HDR_BYTES) : 1;
  localparam logic [CW-1:0] MAX_CNT     = CW'(MAX_HDR_BYTES);
  localparam logic [CW-1:0] OFF_MSB     = CW'(CKSUM_OFFSET);
  localparam logic [CW-1:0] OFF_LSB     = CW'(CKSUM_OFFSET + 1);
  localparam logic [CW-1:0] ONE         = CW'(1);
  localparam logic [CW:0]   MIN_SUB_LEN = (CW+1)'(CKSUM_OFFSET + 2);

  typedef enum logic [1:0] {IDLE, CAPTURE, FOLD, EMIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] rd_q, rd_d;
  logic [31:0]   sum_q, sum_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   cksum_q, cksum_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    buf_q [MAX_HDR_BYTES];

  logic          wr_en;
  logic          in_fire;
  logic          out_fire;
  logic          ovf_now;
  logic          ihl_bad;
  logic [15:0]   addend;

  assign in_ready    = !reset && ((state_q == IDLE) || (state_q == CAPTURE));
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign ovf_now     = ovf_q || (cnt_q >= MAX_CNT);
  assign cksum_done  = done_q;
  assign cksum_value = cksum_q;
  assign hdr_error   = err_q;

  // Word contribution of the incoming byte: even index is the MSB, odd the
  // LSB, and the checksum field itself always counts as zero.
  always_comb begin
    addend = 16'h0000;
    if ((cnt_q != OFF_MSB) && (cnt_q != OFF_LSB)) begin
      addend = cnt_q[0] ? {8'h00, in_data} : {in_data, 8'h00};
    end
  end

`ifdef IPV4_CHECKSUM_IHL_CHECK_EN
  logic [3:0] ihl;

  // IHL comes from byte 0, which is still on in_data for a one-byte frame.
  always_comb begin
    ihl     = (cnt_q == '0) ? in_data[3:0] : buf_q[0][3:0];
    ihl_bad = (ihl < 4'd5) || ((16'(cnt_q) + 16'd1) != {10'd0, ihl, 2'b00});
  end
`else
  assign ihl_bad = 1'b0;
`endif

  // Next-state, datapath updates and stream outputs for the frame FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    rd_d      = rd_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    cksum_d   = cksum_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    wr_en     = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;

    case (state_q)
      IDLE, CAPTURE: begin
        if (in_fire) begin
          if (cnt_q < MAX_CNT) begin
            wr_en = 1'b1;
            sum_d = sum_q + {16'h0000, addend};
            cnt_d = cnt_q + ONE;
          end else begin
            ovf_d = 1'b1;
          end
          if (in_last) begin
            if (ovf_now || ihl_bad) begin
              err_d   = 1'b1;
              state_d = IDLE;
              cnt_d   = '0;
              sum_d   = 32'h0;
              ovf_d   = 1'b0;
            end else begin
              len_d   = cnt_q + ONE;
              state_d = FOLD;
            end
          end else begin
            state_d = CAPTURE;
          end
        end
      end

      FOLD: begin
        if (sum_q[31:16] != 16'h0000) begin
          sum_d = {16'h0000, sum_q[31:16]} + {16'h0000, sum_q[15:0]};
        end else begin
          cksum_d = ~sum_q[15:0];
          rd_d    = '0;
          state_d = EMIT;
        end
      end

      EMIT: begin
        out_valid = 1'b1;
        out_data  = buf_q[AW'(rd_q)];
        if ({1'b0, len_q} >= MIN_SUB_LEN) begin
          if (rd_q == OFF_MSB) begin
            out_data = cksum_q[15:8];
          end else if (rd_q == OFF_LSB) begin
            out_data = cksum_q[7:0];
          end
        end
        out_last = (rd_q == (len_q - ONE));
        if (out_fire) begin
          if (rd_q == (len_q - ONE)) begin
            done_d  = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
            sum_d   = 32'h0;
            ovf_d   = 1'b0;
          end else begin
            rd_d = rd_q + ONE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and control registers; reset abandons any frame in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      rd_q    <= '0;
      sum_q   <= 32'h0;
      ovf_q   <= 1'b0;
      cksum_q <= 16'h0000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      rd_q    <= rd_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      cksum_q <= cksum_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Header byte store; contents need no reset since len_q gates replay.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      buf_q[AW'(cnt_q)] <= in_data;
    end
  end

endmodule

// File: tb/tb_ipv4_checksum_insert.sv
// Self-checking bench for ipv4_checksum_insert: directed header cases plus
// randomized frames against a behavioural checksum model.
module tb_ipv4_checksum_insert;

  localparam int MAXB = 60;
  localparam int OFF  = 10;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic        cksum_done;
  logic [15:0] cksum_value;
  logic        hdr_error;

  int checks = 0;
  int errors = 0;

  logic [7:0] frm_q [$];
  logic [7:0] got_q [$];
  int         last_q [$];
  int         doneCnt, errCnt, outSeen, holdErrs, latency;
  bit         timedOut, abortOutValid, abortInReady;

  logic [7:0] GOLD [20] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                            8'h00, 8'h00, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'hc7};

  ipv4_checksum_insert #(.MAX_HDR_BYTES(MAXB), .CKSUM_OFFSET(OFF)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .cksum_done(cksum_done), .cksum_value(cksum_value), .hdr_error(hdr_error)
  );

  always #5 clock = ~clock;

  // Reference: is the frame in frm_q expected to be dropped?
  function automatic bit model_drop();
    if (frm_q.size() > MAXB) return 1'b1;
`ifdef IPV4_CHECKSUM_IHL_CHECK_EN
    if ((frm_q[0][3:0] < 5) || (frm_q.size() != int'(frm_q[0][3:0]) * 4)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Reference: ones-complement sum of big-endian words, checksum field as zero.
  function automatic logic [15:0] model_cksum();
    longint unsigned s;
    logic [15:0] r;
    s = 0;
    for (int i = 0; i < frm_q.size(); i++) begin
      longint unsigned b;
      b = (i == OFF || i == OFF + 1) ? 0 : longint'(frm_q[i]);
      s += (i % 2 == 0) ? b * 256 : b;
    end
    while (s > 65535) s = (s % 65536) + (s / 65536);
    r = s[15:0];
    return ~r;
  endfunction

  // Reference: expected output byte i of the current frame.
  function automatic logic [7:0] model_out(int i);
    logic [15:0] c;
    c = model_cksum();
    if (frm_q.size() >= OFF + 2) begin
      if (i == OFF) return c[15:8];
      if (i == OFF + 1) return c[7:0];
    end
    return frm_q[i];
  endfunction

  function automatic int count_bad_bytes();
    int bad;
    bad = (got_q.size() != frm_q.size()) ? 1 : 0;
    for (int i = 0; i < frm_q.size(); i++) begin
      if (i >= got_q.size()) bad++;
      else if (got_q[i] !== model_out(i)) bad++;
    end
    return bad;
  endfunction

  task automatic load_golden();
    frm_q.delete();
    for (int i = 0; i < 20; i++) frm_q.push_back(GOLD[i]);
  endtask

  // Drive frm_q into the DUT and record everything seen on the output side.
  task automatic run_frame(input int rdyMode, input bit inGaps, input int abortAt);
    int i = 0;
    int cyc = 0;
    int tail = 0;
    int lastInCyc = -1;
    int firstOutCyc = -1;
    bit prevStall = 1'b0;
    logic [7:0] prevData = 8'h00;
    logic prevLast = 1'b0;
    got_q.delete();
    last_q.delete();
    doneCnt = 0; errCnt = 0; outSeen = 0; holdErrs = 0; latency = 0;
    timedOut = 1'b0; abortOutValid = 1'b0; abortInReady = 1'b0;
    while (1) begin
      @(negedge clock);
      if (cksum_done) doneCnt++;
      if (hdr_error) errCnt++;
      if (prevStall && (!out_valid || out_data !== prevData || out_last !== prevLast)) holdErrs++;
      if (out_valid) begin
        outSeen++;
        if (firstOutCyc < 0) firstOutCyc = cyc;
      end
      if (abortAt >= 0 && out_valid && got_q.size() == abortAt) begin
        out_ready = 1'b0;
        reset = 1'b1;
        #1;
        abortOutValid = out_valid;
        abortInReady = in_ready;
        break;
      end
      if (i < frm_q.size()) begin
        in_valid = inGaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_data  = frm_q[i];
        in_last  = (i == frm_q.size() - 1);
      end else begin
        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
      end
      case (rdyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
      if (in_valid && in_ready) begin
        if (in_last) lastInCyc = cyc;
        i++;
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        if (out_last) last_q.push_back(got_q.size() - 1);
      end
      prevStall = out_valid && !out_ready;
      prevData  = out_data;
      prevLast  = out_last;
      if (i == frm_q.size() && (doneCnt + errCnt) > 0) begin
        tail++;
        if (tail > 3) break;
      end
      cyc++;
      if (cyc > 3000) begin
        timedOut = 1'b1;
        break;
      end
    end
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    if (abortAt < 0) out_ready = 1'b1;
    latency = (firstOutCyc >= 0 && lastInCyc >= 0) ? firstOutCyc - lastInCyc : -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++;
    if ({out_valid, out_last, cksum_done, hdr_error} !== 4'b0000 || out_data !== 8'h00 || cksum_value !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got v=%b l=%b d=%h done=%b err=%b ck=%h expected all zero",
               out_valid, out_last, out_data, cksum_done, hdr_error, cksum_value);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_golden();
    int bad;
    load_golden();
    run_frame(0, 1'b0, -1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] exp;
      exp = (i == 10) ? 8'hB8 : (i == 11) ? 8'h61 : GOLD[i];
      if (i >= got_q.size() || got_q[i] !== exp) bad++;
    end
    checks++;
    if (bad != 0 || got_q.size() != 20) begin
      errors++; $display("[TB] FAIL golden_bytes: got %0d bytes with %0d wrong expected 20 correct", got_q.size(), bad);
    end
    checks++;
    if (cksum_value !== 16'hB861) begin errors++; $display("[TB] FAIL golden_cksum: got %h expected b861", cksum_value); end
    checks++;
    if (doneCnt != 1 || errCnt != 0) begin
      errors++; $display("[TB] FAIL golden_pulses: got done=%0d err=%0d expected 1/0", doneCnt, errCnt);
    end
    checks++;
    if (last_q.size() != 1 || last_q[0] != 19) begin
      errors++; $display("[TB] FAIL golden_last: got %0d last markers expected one at 19", last_q.size());
    end
    checks++;
    if (latency < 0 || latency > 4) begin errors++; $display("[TB] FAIL golden_latency: got %0d expected 0..4", latency); end
  endtask

  task automatic test_ff_field();
    int bad;
    load_golden();
    frm_q[10] = 8'hFF;
    frm_q[11] = 8'hFF;
    run_frame(0, 1'b0, -1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] exp;
      exp = (i == 10) ? 8'hB8 : (i == 11) ? 8'h61 : GOLD[i];
      if (i >= got_q.size() || got_q[i] !== exp) bad++;
    end
    checks++;
    if (bad != 0 || cksum_value !== 16'hB861) begin
      errors++; $display("[TB] FAIL ff_field: got %0d wrong bytes ck=%h expected 0 wrong ck=b861", bad, cksum_value);
    end
  endtask

  task automatic test_backpressure();
    load_golden();
    run_frame(1, 1'b0, -1);
    checks++;
    if (count_bad_bytes() != 0) begin errors++; $display("[TB] FAIL bp_bytes: got %0d wrong bytes expected 0", count_bad_bytes()); end
    checks++;
    if (holdErrs != 0) begin errors++; $display("[TB] FAIL bp_hold: got %0d unstable stalls expected 0", holdErrs); end
    checks++;
    if (last_q.size() != 1 || got_q.size() != 20 || got_q[19] !== 8'hC7 || last_q[0] != 19) begin
      errors++; $display("[TB] FAIL bp_last: got %0d markers, %0d bytes expected one marker on c7", last_q.size(), got_q.size());
    end
    checks++;
    if (doneCnt != 1) begin errors++; $display("[TB] FAIL bp_done: got %0d expected 1", doneCnt); end
  endtask

  task automatic test_short();
    frm_q = '{8'h01, 8'h02, 8'h03};
    run_frame(0, 1'b0, -1);
    if (model_drop()) begin
      checks++;
      if (errCnt != 1 || outSeen != 0) begin
        errors++; $display("[TB] FAIL short_drop: got err=%0d out=%0d expected 1/0", errCnt, outSeen);
      end
    end else begin
      checks++;
      if (got_q.size() != 3 || got_q[0] !== 8'h01 || got_q[1] !== 8'h02 || got_q[2] !== 8'h03) begin
        errors++; $display("[TB] FAIL short_bytes: got %0d bytes expected 01 02 03", got_q.size());
      end
      checks++;
      if (cksum_value !== 16'hFBFD || model_cksum() !== 16'hFBFD) begin
        errors++; $display("[TB] FAIL short_cksum: got %h expected fbfd", cksum_value);
      end
    end
  endtask

  task automatic test_overflow();
    frm_q.delete();
    for (int i = 0; i < 64; i++) frm_q.push_back(8'($urandom));
    run_frame(0, 1'b0, -1);
    checks++;
    if (errCnt != 1 || outSeen != 0 || doneCnt != 0) begin
      errors++; $display("[TB] FAIL ovf_drop: got err=%0d out=%0d done=%0d expected 1/0/0", errCnt, outSeen, doneCnt);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ovf_ready: got %b expected 1", in_ready); end
    load_golden();
    run_frame(0, 1'b0, -1);
    checks++;
    if (count_bad_bytes() != 0 || cksum_value !== 16'hB861 || doneCnt != 1) begin
      errors++; $display("[TB] FAIL ovf_recover: got %0d wrong bytes ck=%h done=%0d expected 0/b861/1",
                         count_bad_bytes(), cksum_value, doneCnt);
    end
  endtask

  task automatic test_reset_mid_emit();
    int stray = 0;
    load_golden();
    run_frame(0, 1'b0, 7);
    checks++;
    if (abortOutValid !== 1'b0 || abortInReady !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_outputs: got v=%b rdy=%b expected 0/0", abortOutValid, abortInReady);
    end
    @(negedge clock);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (out_valid || cksum_done || hdr_error) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("[TB] FAIL abort_quiet: got %0d active cycles expected 0", stray); end
    load_golden();
    run_frame(0, 1'b0, -1);
    checks++;
    if (count_bad_bytes() != 0 || cksum_value !== 16'hB861 || doneCnt != 1) begin
      errors++; $display("[TB] FAIL abort_recover: got %0d wrong bytes ck=%h done=%0d expected 0/b861/1",
                         count_bad_bytes(), cksum_value, doneCnt);
    end
    load_golden();
    void'(frm_q.pop_back());
    run_frame(0, 1'b0, -1);
    checks++;
    if (model_drop()) begin
      if (errCnt != 1 || outSeen != 0) begin
        errors++; $display("[TB] FAIL len19_drop: got err=%0d out=%0d expected 1/0", errCnt, outSeen);
      end
    end else if (count_bad_bytes() != 0 || doneCnt != 1 || cksum_value !== model_cksum()) begin
      errors++; $display("[TB] FAIL len19_frame: got %0d wrong bytes ck=%h expected 0/%h",
                         count_bad_bytes(), cksum_value, model_cksum());
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      int len;
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(MAXB + 1, MAXB + 10) : $urandom_range(1, MAXB);
      frm_q.delete();
      for (int i = 0; i < len; i++) frm_q.push_back(8'($urandom));
      run_frame(2, ($urandom_range(0, 1) == 1), -1);
      checks++;
      if (timedOut) begin
        errors++; $display("[TB] FAIL rand_timeout: frame %0d len %0d got no completion expected one", f, len);
      end else if (model_drop()) begin
        if (errCnt != 1 || outSeen != 0 || doneCnt != 0) begin
          errors++; $display("[TB] FAIL rand_drop: frame %0d got err=%0d out=%0d done=%0d expected 1/0/0",
                             f, errCnt, outSeen, doneCnt);
        end
      end else if (count_bad_bytes() != 0 || doneCnt != 1 || errCnt != 0 || cksum_value !== model_cksum()
                   || last_q.size() != 1 || last_q[0] != len - 1 || holdErrs != 0 || latency < 0 || latency > 4) begin
        errors++;
        $display("[TB] FAIL rand_frame: frame %0d len %0d got bad=%0d done=%0d err=%0d ck=%h lasts=%0d hold=%0d lat=%0d expected 0/1/0/%h/1/0/<=4",
                 f, len, count_bad_bytes(), doneCnt, errCnt, cksum_value, last_q.size(), holdErrs, latency, model_cksum());
      end
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_ff_field();
    test_backpressure();
    test_short();
    test_overflow();
    test_reset_mid_emit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ipv4_checksum_insert.md
IPV4_CHECKSUM_INSERT -- requirements
Module: ipv4_checksum_insert

Interface
REQ-001 SHALL have parameter MAX_HDR_BYTES, default 60: frame buffer depth in bytes.
REQ-002 SHALL have parameter CKSUM_OFFSET, default 10: byte index of the checksum MSB; the LSB is at CKSUM_OFFSET+1.
REQ-003 SHALL have port clock  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  input byte valid.
REQ-006 SHALL have port in_data  input  8  header byte, first byte first.
REQ-007 SHALL have port in_last  input  1  marks the final byte of the header.
REQ-008 SHALL have port in_ready  output  1  block accepts an input byte.
REQ-009 SHALL have port out_valid  output  1  output byte valid.
REQ-010 SHALL have port out_data  output  8  header byte with the checksum inserted.
REQ-011 SHALL have port out_last  output  1  marks the final output byte.
REQ-012 SHALL have port out_ready  input  1  downstream accepts a byte.
REQ-013 SHALL have port cksum_done  output  1  one-cycle pulse after the last output byte transfers.
REQ-014 SHALL have port cksum_value  output  16  computed checksum; held until the next cksum_done.
REQ-015 SHALL have port hdr_error  output  1  one-cycle pulse when a frame is dropped.

Function
REQ-016 SHALL transfer a byte on any edge where valid and ready are both high, on both input and output.
REQ-017 SHALL implement states IDLE, CAPTURE, FOLD and EMIT.
- IDLE -> CAPTURE on the first accepted byte.
- CAPTURE -> FOLD on an accepted byte with in_last=1.
- FOLD -> EMIT when the fold completes.
- EMIT -> IDLE on the transfer of the last byte.
REQ-018 SHALL drive in_ready=1 only in IDLE and CAPTURE, and out_valid=1 only in EMIT.
REQ-019 SHALL store every accepted byte at buffer index n, where n counts from 0 per frame.
REQ-020 SHALL accumulate a 32-bit sum of big-endian 16-bit words:
- even index n -> byte is the MSB of the word;
- odd index n -> byte is the LSB of the word.
REQ-021 SHALL sum bytes CKSUM_OFFSET and CKSUM_OFFSET+1 as zero, whatever their input value.
REQ-022 SHALL pad an odd-length frame's final byte with 0x00 as the LSB of the last word.
REQ-023 In FOLD, SHALL do one step per cycle: if sum[31:16]!=0, set sum to sum[31:16]+sum[15:0]; otherwise latch cksum_value = ~sum[15:0] and enter EMIT on the next cycle.
REQ-024 In EMIT, SHALL output buffered bytes 0..len-1 in order, with these substitutions:
- byte CKSUM_OFFSET -> cksum_value[15:8];
- byte CKSUM_OFFSET+1 -> cksum_value[7:0].
REQ-025 SHALL output unchanged any frame whose length is less than CKSUM_OFFSET+2; cksum_value is still computed and reported.
REQ-026 SHALL assert out_last with byte len-1 only.
REQ-027 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-028 SHALL pulse cksum_done for exactly one cycle, on the cycle after the last output transfer.
REQ-029 On a byte accepted at index >= MAX_HDR_BYTES:
- SHALL discard the byte and set an overflow flag;
- at in_last, SHALL pulse hdr_error, emit nothing, skip cksum_done and return to IDLE.
REQ-030 SHALL treat a one-byte frame (in_valid and in_last in the same transfer from IDLE) as a valid frame.
REQ-031 SHALL have a first out_valid no later than 4 cycles after the in_last transfer.

Reset
REQ-032 On reset, SHALL enter IDLE and clear the byte count, sum and overflow flag.
REQ-033 On reset, SHALL drive in_ready=0 while reset is asserted, then 1 in IDLE.
REQ-034 On reset, SHALL drive out_valid=0, out_last=0, out_data=0x00, cksum_done=0, hdr_error=0 and cksum_value=0x0000.
REQ-035 SHALL abort any frame in progress on reset mid-frame; no partial output and no done pulse follow.

Configuration
REQ-036 With macro IPV4_CHECKSUM_IHL_CHECK_EN defined:
- SHALL take byte 0 bits[3:0] as IHL;
- SHALL pulse hdr_error and drop the frame if IHL<5 or the frame length != IHL*4.
REQ-037 Without IPV4_CHECKSUM_IHL_CHECK_EN, SHALL perform no IHL check; only the overflow rule of REQ-029 drops frames.

Verification
REQ-038 Input header 45 00 00 73 00 00 40 00 40 11 00 00 c0 a8 00 01 c0 a8 00 c7 with out_ready=1 -> output matches input except bytes 10/11 = B8 61; cksum_value=0xB861; one cksum_done pulse.
REQ-039 Same header with bytes 10/11 = FF FF -> identical output, with bytes 10/11 = B8 61.
REQ-040 Same header with out_ready toggling 1,0,0,1 repeatedly -> 20 bytes in order; out_data held during stalls; out_last only on byte 0xC7.
REQ-041 3-byte frame 01 02 03 -> output 01 02 03 unchanged; cksum_value=0xFBFD.
REQ-042 64-byte frame -> hdr_error pulse; no out_valid; in_ready=1 afterwards; the next 20-byte header is processed correctly.
REQ-043 Reset asserted during EMIT at byte 7 -> out_valid=0 immediately; the following frame is correct; with IPV4_CHECKSUM_IHL_CHECK_EN, a 19-byte frame with byte 0 = 0x45 -> hdr_error.
